// File: rtl/apb_master.sv
// APB3 requester: one valid/ready command becomes one SETUP/ACCESS transfer and one response.
// Latency: 4 cycles minimum per transfer; optional ACCESS timeout via APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pwrite,
  output logic                  psel,
  output logic                  penable,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                  state, state_nxt;
  logic                    psel_nxt, penable_nxt, pwrite_nxt;
  logic [ADDR_WIDTH-1:0]   paddr_nxt;
  logic [DATA_WIDTH-1:0]   pwdata_nxt;
  logic                    rsp_valid_nxt, rsp_err_nxt;
  logic [DATA_WIDTH-1:0]   rsp_rdata_nxt;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Abort on the wait cycle that brings the count up to TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt, cnt_nxt;
`else
  // TIMEOUT_CYCLES only matters when the timeout is built in.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  assign cmd_ready = (state == IDLE) && !rst;

  always_comb begin
    state_nxt     = state;
    psel_nxt      = psel;
    penable_nxt   = penable;
    pwrite_nxt    = pwrite;
    paddr_nxt     = paddr;
    pwdata_nxt    = pwdata;
    rsp_valid_nxt = rsp_valid;
    rsp_rdata_nxt = rsp_rdata;
    rsp_err_nxt   = rsp_err;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_nxt       = cnt;
`endif
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nxt   = SETUP;
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
          pwrite_nxt  = cmd_write;
          paddr_nxt   = cmd_addr;
          pwdata_nxt  = cmd_write ? cmd_wdata : '0;
        end
      end
      SETUP: begin
        state_nxt   = ACCESS;
        penable_nxt = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_nxt     = '0;
`endif
      end
      ACCESS: begin
        if (pready) begin
          state_nxt     = RESP;
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = pwrite ? '0 : prdata;
          rsp_err_nxt   = pslverr;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (cnt == TO_LIM) begin
          state_nxt     = RESP;
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = '0;
          rsp_err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      state     <= state_nxt;
      psel      <= psel_nxt;
      penable   <= penable_nxt;
      pwrite    <= pwrite_nxt;
      paddr     <= paddr_nxt;
      pwdata    <= pwdata_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      rsp_err   <= rsp_err_nxt;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt       <= cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: zero-wait write, wait-state read, error with backpressure,
// back-to-back commands, mid-ACCESS reset and stuck-pready behaviour.
module tb_apb_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [4:0]  paddr;
  logic        pwrite, psel, penable;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;

  int checks = 0;
  int errors = 0;

  apb_master #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [4:0] a, input logic [31:0] d);
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    check("issue_rdy", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  logic [4:0] b2b_addr [3] = '{5'h01, 5'h02, 5'h03};
  logic       b2b_wr   [3] = '{1'b1, 1'b0, 1'b1};

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1; prdata = '0; pready = 1'b1; pslverr = 1'b0;
    tick(); tick();
    check("rst_rdy", cmd_ready, 0);
    check("rst_psel", psel, 0);
    check("rst_pen", penable, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_rvld", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_rerr", rsp_err, 0);
    rst = 1'b0;
    #1;
    check("idle_rdy", cmd_ready, 1);

    // Zero-wait write
    issue(1'b1, 5'h04, 32'h1234_5678);
    check("wr_c1_psel", psel, 1);
    check("wr_c1_pen", penable, 0);
    check("wr_c1_paddr", paddr, 5'h04);
    check("wr_c1_pwrite", pwrite, 1);
    check("wr_c1_pwdata", pwdata, 32'h1234_5678);
    check("wr_c1_rdy", cmd_ready, 0);
    tick();
    check("wr_c2_psel", psel, 1);
    check("wr_c2_pen", penable, 1);
    tick();
    check("wr_c3_psel", psel, 0);
    check("wr_c3_pen", penable, 0);
    check("wr_c3_rvld", rsp_valid, 1);
    check("wr_c3_rdata", rsp_rdata, 0);
    check("wr_c3_rerr", rsp_err, 0);
    tick();
    check("wr_c4_rvld", rsp_valid, 0);
    check("wr_c4_rdy", cmd_ready, 1);
    check("wr_c4_paddr_hold", paddr, 5'h04);

    // Read with 3 wait states; junk on prdata/pslverr must be ignored
    pready = 1'b0; prdata = 32'hDEAD_BEEF; pslverr = 1'b1;
    issue(1'b0, 5'h08, 32'hFFFF_FFFF);
    check("rd_setup_pwdata", pwdata, 0);
    check("rd_setup_pwrite", pwrite, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("rd_wait_pen", penable, 1);
      check("rd_wait_paddr", paddr, 5'h08);
      check("rd_wait_rvld", rsp_valid, 0);
      tick();
    end
    pready = 1'b1; prdata = 32'hCAFE_F00D; pslverr = 1'b0;
    check("rd_last_pen", penable, 1);
    check("rd_last_paddr", paddr, 5'h08);
    tick();
    pready = 1'b0; prdata = 32'h0;
    check("rd_rvld", rsp_valid, 1);
    check("rd_rdata", rsp_rdata, 32'hCAFE_F00D);
    check("rd_rerr", rsp_err, 0);
    check("rd_psel", psel, 0);
    tick();

    // Slave error with response backpressure
    rsp_ready = 1'b0; pready = 1'b1; pslverr = 1'b1; prdata = 32'h55AA_55AA;
    issue(1'b0, 5'h1F, 32'h0);
    tick(); tick();
    pslverr = 1'b0; prdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      check("bp_rvld", rsp_valid, 1);
      check("bp_rerr", rsp_err, 1);
      check("bp_rdata", rsp_rdata, 32'h55AA_55AA);
      check("bp_rdy", cmd_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_rel_rdy", cmd_ready, 0);
    tick();
    check("bp_done_rvld", rsp_valid, 0);
    check("bp_done_rdy", cmd_ready, 1);

    // Back-to-back with cmd_valid held high
    begin
      int   acc = 0;
      int   setups = 0;
      int   rsps = 0;
      logic prev_psel = 1'b0;
      logic hs;
      pready = 1'b1;
      cmd_write = b2b_wr[0]; cmd_addr = b2b_addr[0]; cmd_wdata = 32'h0000_0A00;
      cmd_valid = 1'b1;
      for (int c = 0; c < 24; c++) begin
        hs = cmd_valid && cmd_ready;
        tick();
        if (hs) begin
          acc++;
          if (acc < 3) begin
            cmd_write = b2b_wr[acc]; cmd_addr = b2b_addr[acc]; cmd_wdata = 32'h0000_0A00 + acc;
          end else begin
            cmd_valid = 1'b0;
          end
        end
        if (psel && !penable) begin
          check("b2b_prev_psel", prev_psel, 0);
          check("b2b_paddr", paddr, b2b_addr[setups]);
          check("b2b_pwrite", pwrite, b2b_wr[setups]);
          setups++;
        end
        if (rsp_valid) rsps++;
        prev_psel = psel;
      end
      check("b2b_accepted", acc, 3);
      check("b2b_setups", setups, 3);
      check("b2b_rsps", rsps, 3);
    end

    // Reset asserted mid-ACCESS
    pready = 1'b0;
    issue(1'b0, 5'h0A, 32'h0);
    tick(); tick();
    check("mr_psel", psel, 1);
    check("mr_pen", penable, 1);
    rst = 1'b1;
    tick();
    check("mr_psel0", psel, 0);
    check("mr_pen0", penable, 0);
    check("mr_paddr0", paddr, 0);
    check("mr_rvld0", rsp_valid, 0);
    check("mr_rdy0", cmd_ready, 0);
    rst = 1'b0; pready = 1'b1;
    #1;
    check("mr_rdy1", cmd_ready, 1);
    tick();
    check("mr_norsp", rsp_valid, 0);
    issue(1'b1, 5'h11, 32'hA5A5_A5A5);
    tick(); tick();
    check("mr_next_rvld", rsp_valid, 1);
    check("mr_next_rerr", rsp_err, 0);
    check("mr_next_pwdata", pwdata, 32'hA5A5_A5A5);
    tick();

    // pready stuck low
    pready = 1'b0;
    issue(1'b0, 5'h03, 32'h0);
    tick();
`ifdef APB_MASTER_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      check("to_access_psel", psel, 1);
      tick();
    end
    check("to_psel", psel, 0);
    check("to_rvld", rsp_valid, 1);
    check("to_rerr", rsp_err, 1);
    check("to_rdata", rsp_rdata, 0);
    pready = 1'b1; prdata = 32'h7777_7777;
    tick();
    pready = 1'b0;
    tick();
    check("to_late_rvld", rsp_valid, 0);
    check("to_late_psel", psel, 0);
    check("to_late_rdy", cmd_ready, 1);
`else
    repeat (100) tick();
    check("nto_psel", psel, 1);
    check("nto_pen", penable, 1);
    check("nto_rvld", rsp_valid, 0);
    pready = 1'b1; prdata = 32'h0BAD_C0DE;
    tick();
    pready = 1'b0;
    check("nto_rdata", rsp_rdata, 32'h0BAD_C0DE);
    check("nto_rerr", rsp_err, 0);
    tick();
    check("nto_done_rdy", cmd_ready, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
